// File: rtl/led_chaser_ctrl.sv
// Command-driven LED chaser: a valid/ready command port programs period, mode and pattern,
// and a tick counter steps the LED register once every programmed number of clocks.
module led_chaser_ctrl #(
   parameter int WIDTH          = 8,
   parameter int PERIOD_W       = 8,
   parameter int DEFAULT_PERIOD = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [2:0]       i_cmd_op,
   input  logic [7:0]       i_cmd_arg,
   output logic [WIDTH-1:0] o_led_out,
   output logic             o_step_pulse,
   output logic             o_running,
   output logic             o_cmd_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOPPING
   } state_t;

   localparam logic [2:0] OP_START       = 3'd1;
   localparam logic [2:0] OP_STOP        = 3'd2;
   localparam logic [2:0] OP_SET_PERIOD  = 3'd3;
   localparam logic [2:0] OP_SET_MODE    = 3'd4;
   localparam logic [2:0] OP_SET_PATTERN = 3'd5;

   localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   state_t              w_stateNext;
   logic [WIDTH-1:0]    r_led;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_tick;
   logic [1:0]          r_mode;
   logic                r_dirLeft;
   logic                r_stepPulse;
   logic                r_cmdErr;

   logic [PERIOD_W-1:0] w_periodEff;
   logic                w_accept;
   logic                w_stepNow;
   logic [WIDTH-1:0]    w_patArg;
   logic                w_cmdErr;
   logic                w_loadPattern;
   logic [WIDTH-1:0]    w_ledStep;
   logic                w_dirStep;

   // A programmed period of zero behaves like one: step on every clock.
   assign w_periodEff   = (r_period == '0) ? PERIOD_ONE : r_period;
   assign w_accept      = i_cmd_valid & o_cmd_ready;
   assign w_stepNow     = (r_state != ST_IDLE) && (r_tick == (w_periodEff - PERIOD_ONE));
   assign w_patArg      = i_cmd_arg[WIDTH-1:0];
   assign w_cmdErr      = w_accept & ((i_cmd_op == 3'd6) | (i_cmd_op == 3'd7) |
                          ((i_cmd_op == OP_SET_PATTERN) & (o_running | (w_patArg == '0))));
   assign w_loadPattern = w_accept & (i_cmd_op == OP_SET_PATTERN) & ~o_running & (w_patArg != '0);

   assign o_led_out    = r_led;
   assign o_step_pulse = r_stepPulse;
   assign o_cmd_err    = r_cmdErr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE:     if (w_accept && (i_cmd_op == OP_START)) w_stateNext = ST_RUN;
         ST_RUN:      if (w_accept && (i_cmd_op == OP_STOP))  w_stateNext = ST_STOPPING;
         ST_STOPPING: if (w_stepNow)                          w_stateNext = ST_IDLE;
         default:     w_stateNext = ST_IDLE;
      endcase
   end

   always_comb begin
      o_running   = (r_state != ST_IDLE);
      o_cmd_ready = (r_state != ST_STOPPING);
   end

   // Bounce flips direction on the step that finds the lit edge, shifting away from it.
   always_comb begin
      w_ledStep = r_led;
      w_dirStep = r_dirLeft;
      case (r_mode)
         2'd0: w_ledStep = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
         2'd1: w_ledStep = {r_led[0], r_led[WIDTH-1:1]};
         2'd2: begin
            if (r_dirLeft) begin
               if (r_led[WIDTH-1]) begin
                  w_dirStep = 1'b0;
                  w_ledStep = r_led >> 1;
               end else begin
                  w_ledStep = r_led << 1;
               end
            end else begin
               if (r_led[0]) begin
                  w_dirStep = 1'b1;
                  w_ledStep = r_led << 1;
               end else begin
                  w_ledStep = r_led >> 1;
               end
            end
         end
         default: w_ledStep = ~r_led;
      endcase
   end

   // Command effects are written after the step so they win on a shared edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_led       <= {{(WIDTH-1){1'b0}}, 1'b1};
         r_period    <= PERIOD_W'(DEFAULT_PERIOD);
         r_tick      <= '0;
         r_mode      <= 2'd0;
         r_dirLeft   <= 1'b1;
         r_stepPulse <= 1'b0;
         r_cmdErr    <= 1'b0;
      end else begin
         r_stepPulse <= w_stepNow;
         r_cmdErr    <= w_cmdErr;
         if (r_state != ST_IDLE) begin
            r_tick <= w_stepNow ? '0 : (r_tick + PERIOD_ONE);
         end
         if (w_stepNow) begin
            r_led     <= w_ledStep;
            r_dirLeft <= w_dirStep;
         end
         if (w_accept) begin
            case (i_cmd_op)
               OP_START: begin
                  if (r_state == ST_IDLE) r_tick <= '0;
               end
               OP_SET_PERIOD: begin
                  r_period <= i_cmd_arg[PERIOD_W-1:0];
                  if (o_running) r_tick <= '0;
               end
               OP_SET_MODE: begin
                  r_mode    <= i_cmd_arg[1:0];
                  r_dirLeft <= 1'b1;
               end
               default: ;
            endcase
         end
         if (w_loadPattern) begin
            r_led     <= w_patArg;
            r_dirLeft <= 1'b1;
         end
      end
   end

endmodule
